// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The fetch state encoding and instruction/PC step sizes live here.
package if_pkg;

   localparam int INST_W  = 32;
   localparam int PC_STEP = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous instruction buffer with push, pop, flush and occupancy count.
// Data width is a parameter so the fetch unit can append a PC tag to each entry.
module if_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = INST_W
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           head_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             doPush;
   logic             doPop;

   // A pop frees its slot in the same cycle, so push-while-full is legal only alongside a pop.
   always_comb begin
      doPop    = pop_i && (count_q != '0);
      doPush   = push_i && ((count_q != DEPTH_C) || doPop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (doPush) wr_ptr_d = wr_ptr_q + 1'b1;
         if (doPop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (doPush && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign empty_o = (count_q == '0);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: issues in-order word reads, buffers responses, handles redirects.
// Define IF_PC_TAG_EN to add inst_tpc, the fetch address of the presented instruction.
module instruction_fetch
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic              aclk,
   input  logic              aresetn,
   output logic              imem_req,
   output logic [31:0]       imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_rvalid,
   output logic [INST_W-1:0] inst_tdata,
   output logic              inst_tvalid,
   input  logic              inst_tready,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc
`ifdef IF_PC_TAG_EN
   ,
   output logic [31:0]       inst_tpc
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
`ifdef IF_PC_TAG_EN
   localparam int ENTRY_W = INST_W + 32;
`else
   localparam int ENTRY_W = INST_W;
`endif

   if_state_e        state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CW-1:0]    outstanding_q, outstanding_d;
   logic [CW-1:0]    drop_q, drop_d;

   logic [31:0]      redirectTarget;
   logic [CW-1:0]    fifoCount;
   logic             fifoEmpty;
   logic             fifoPush;
   logic             fifoPop;
   logic             fifoFlush;
   logic [ENTRY_W-1:0] fifoPushData;
   logic [ENTRY_W-1:0] fifoHead;
   logic             bufferRoom;
   logic             rspAccept;
   logic             dropHit;
   logic [CW-1:0]    redirectDrop;
   logic [CW-1:0]    flushDropLeft;
   logic             unusedRedirectBits;

   assign redirectTarget     = {redirect_pc[31:2], 2'b00};
   assign unusedRedirectBits = ^redirect_pc[1:0];

   // Responses only count against real in-flight requests; strays are dropped on the floor.
   assign rspAccept     = imem_rvalid && (outstanding_q != '0);
   assign dropHit       = imem_rvalid && (drop_q != '0);
   assign redirectDrop  = outstanding_q - CW'(rspAccept);
   assign flushDropLeft = drop_q - CW'(dropHit);
   assign bufferRoom    = ({1'b0, fifoCount} + {1'b0, outstanding_q}) < DEPTH_W;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      imem_req      = 1'b0;
      fifoPush      = 1'b0;
      fifoFlush     = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redirect) pc_d = redirectTarget;
         end
         FETCH: begin
            if (redirect) begin
               pc_d          = redirectTarget;
               fifoFlush     = 1'b1;
               outstanding_d = '0;
               drop_d        = redirectDrop;
               state_d       = (redirectDrop != '0) ? FLUSH : FETCH;
            end else begin
               imem_req      = bufferRoom;
               fifoPush      = rspAccept;
               if (bufferRoom) pc_d = pc_q + 32'(PC_STEP);
               outstanding_d = outstanding_q + CW'(bufferRoom) - CW'(rspAccept);
            end
         end
         FLUSH: begin
            drop_d = flushDropLeft;
            if (redirect) begin
               pc_d      = redirectTarget;
               fifoFlush = 1'b1;
            end
            if (flushDropLeft == '0) state_d = FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

`ifdef IF_PC_TAG_EN
   // Requests since the last redirect are consecutive, so the oldest one sits behind pc.
   logic [31:0] rspPc;
   assign rspPc        = pc_q - (32'(outstanding_q) << 2);
   assign fifoPushData = {rspPc, imem_rdata};
   assign inst_tpc     = fifoHead[ENTRY_W-1:INST_W];
`else
   assign fifoPushData = imem_rdata;
`endif

   assign fifoPop = inst_tvalid && inst_tready;

   if_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i       (aclk),
      .rst_ni      (aresetn),
      .push_i      (fifoPush),
      .push_data_i (fifoPushData),
      .pop_i       (fifoPop),
      .flush_i     (fifoFlush),
      .head_o      (fifoHead),
      .empty_o     (fifoEmpty),
      .count_o     (fifoCount)
   );

   assign imem_addr   = imem_req ? pc_q : 32'h0;
   assign inst_tvalid = !fifoEmpty;
   assign inst_tdata  = fifoHead[INST_W-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a configurable-latency memory model.
// Honours IF_PC_TAG_EN for the optional inst_tpc checks.
module tb_instruction_fetch;

   logic        aclk;
   logic        aresetn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] inst_tdata;
   logic        inst_tvalid;
   logic        inst_tready;
   logic        redirect;
   logic [31:0] redirect_pc;
`ifdef IF_PC_TAG_EN
   logic [31:0] inst_tpc;
`endif

   int errors = 0;
   int checks = 0;

   logic [3:0]  pipeV;
   logic [31:0] pipeA [0:3];
   logic [1:0]  latSel;
   logic        strayV;

   instruction_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_rvalid (imem_rvalid),
      .inst_tdata  (inst_tdata),
      .inst_tvalid (inst_tvalid),
      .inst_tready (inst_tready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
`ifdef IF_PC_TAG_EN
      ,
      .inst_tpc    (inst_tpc)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'h0011_0113 + (a << 8);
   endfunction

   // Memory keeps delivering across reset so stale responses can be observed.
   always @(posedge aclk) begin
      pipeV    <= {pipeV[2:0], imem_req};
      pipeA[0] <= imem_addr;
      pipeA[1] <= pipeA[0];
      pipeA[2] <= pipeA[1];
      pipeA[3] <= pipeA[2];
   end

   assign imem_rvalid = pipeV[latSel] | strayV;
   assign imem_rdata  = strayV ? 32'hDEAD_BEEF : memWord(pipeA[latSel]);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy);
      redirect    = redir;
      redirect_pc = rpc;
      inst_tready = rdy;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge aclk);
      #2;
   endtask

   // Leaves the bench one tick into cycle 0, the first cycle after release.
   task automatic resetDut(input logic [1:0] lat, input logic rdy);
      aresetn     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      strayV      = 1'b0;
      inst_tready = rdy;
      latSel      = lat;
      repeat (5) @(posedge aclk);
      #2;
      aresetn = 1'b1;
      #1;
   endtask

   initial begin
      int reqs;
      int unstable;
      int badCycles;

      aresetn     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_tready = 1'b0;
      strayV      = 1'b0;
      latSel      = 2'd0;

      $display("[TB] streaming fetch, 1-cycle memory");
      resetDut(2'd0, 1'b1);
      checkOutput("A_c0_req", imem_req, 1'b0);
      checkOutput("A_c0_addr", imem_addr, 32'h0);
      checkOutput("A_c0_tvalid", inst_tvalid, 1'b0);
      checkOutput("A_c0_tdata", inst_tdata, 32'h0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("A_c1_req", imem_req, 1'b1);
      checkOutput("A_c1_addr", imem_addr, 32'h0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("A_c2_addr", imem_addr, 32'h4);
      checkOutput("A_c2_tvalid", inst_tvalid, 1'b0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("A_c3_tvalid", inst_tvalid, 1'b1);
      checkOutput("A_c3_tdata", inst_tdata, 32'h0011_0113);
      checkOutput("A_c3_req", imem_req, 1'b0);
`ifdef IF_PC_TAG_EN
      checkOutput("A_c3_tpc", inst_tpc, 32'h0);
`endif
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("A_c4_tdata", inst_tdata, 32'h0011_0513);
      checkOutput("A_c4_addr", imem_addr, 32'h8);
`ifdef IF_PC_TAG_EN
      checkOutput("A_c4_tpc", inst_tpc, 32'h4);
`endif
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("A_c5_addr", imem_addr, 32'hC);
      checkOutput("A_c5_tvalid", inst_tvalid, 1'b0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("A_c6_tdata", inst_tdata, 32'h0011_0913);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("A_c7_tvalid", inst_tvalid, 1'b1);
      checkOutput("A_c7_addr", imem_addr, 32'h10);
      aresetn = 1'b0;
      #1;
      checkOutput("A_rst_req", imem_req, 1'b0);
      checkOutput("A_rst_addr", imem_addr, 32'h0);
      checkOutput("A_rst_tvalid", inst_tvalid, 1'b0);
      checkOutput("A_rst_tdata", inst_tdata, 32'h0);
`ifdef IF_PC_TAG_EN
      checkOutput("A_rst_tpc", inst_tpc, 32'h0);
`endif

      $display("[TB] backpressure for ten cycles");
      resetDut(2'd0, 1'b0);
      reqs     = 0;
      unstable = 0;
      for (int c = 1; c <= 12; c++) begin
         nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0);
         if (imem_req) reqs++;
         if (c >= 3 && inst_tdata !== 32'h0011_0113) unstable++;
      end
      checkOutput("B_req_count", 32'(reqs), 32'd2);
      checkOutput("B_tdata_unstable", 32'(unstable), 32'd0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("B_c13_tdata", inst_tdata, 32'h0011_0113);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("B_c14_tdata", inst_tdata, 32'h0011_0513);
      checkOutput("B_c14_addr", imem_addr, 32'h8);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("B_c16_tdata", inst_tdata, 32'h0011_0913);

      $display("[TB] redirect with two requests in flight, 3-cycle memory");
      resetDut(2'd2, 1'b1);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("C_c1_addr", imem_addr, 32'h0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("C_c2_addr", imem_addr, 32'h4);
      nextCycle(); applyStimulus(1'b1, 32'h0000_0103, 1'b1);
      badCycles = 0;
      for (int c = 4; c <= 5; c++) begin
         nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
         if (imem_req || inst_tvalid) badCycles++;
      end
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("C_c6_req", imem_req, 1'b1);
      checkOutput("C_c6_addr", imem_addr, 32'h100);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("C_c7_addr", imem_addr, 32'h104);
      for (int c = 8; c <= 9; c++) begin
         nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
         if (inst_tvalid) badCycles++;
      end
      checkOutput("C_flush_quiet", 32'(badCycles), 32'd0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("C_c10_tvalid", inst_tvalid, 1'b1);
      checkOutput("C_c10_tdata", inst_tdata, 32'h0012_0113);
`ifdef IF_PC_TAG_EN
      checkOutput("C_c10_tpc", inst_tpc, 32'h100);
`endif
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("C_c11_tdata", inst_tdata, 32'h0012_0513);
`ifdef IF_PC_TAG_EN
      checkOutput("C_c11_tpc", inst_tpc, 32'h104);
`endif

      $display("[TB] stray response and redirect racing a response");
      resetDut(2'd0, 1'b1);
      nextCycle();
      strayV = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("D_c1_addr", imem_addr, 32'h0);
      nextCycle();
      strayV = 1'b0;
      applyStimulus(1'b1, 32'h0000_0200, 1'b1);
      checkOutput("D_c2_req_gated", imem_req, 1'b0);
      checkOutput("D_c2_stray_ignored", inst_tvalid, 1'b0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("D_c3_addr", imem_addr, 32'h200);
      checkOutput("D_c3_tvalid", inst_tvalid, 1'b0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("D_c4_tvalid", inst_tvalid, 1'b0);
      checkOutput("D_c4_addr", imem_addr, 32'h204);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("D_c5_tdata", inst_tdata, 32'h0013_0113);
`ifdef IF_PC_TAG_EN
      checkOutput("D_c5_tpc", inst_tpc, 32'h200);
`endif

      $display("[TB] reset pulse with requests in flight");
      resetDut(2'd2, 1'b1);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("E_c1_addr", imem_addr, 32'h0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("E_c2_addr", imem_addr, 32'h4);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      aresetn = 1'b0;
      #1;
      checkOutput("E_rst_req", imem_req, 1'b0);
      checkOutput("E_rst_tvalid", inst_tvalid, 1'b0);
      nextCycle();
      aresetn = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("E_c0_req", imem_req, 1'b0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("E_c1_req", imem_req, 1'b1);
      checkOutput("E_c1_addr", imem_addr, 32'h0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("E_c2_stale_ignored", inst_tvalid, 1'b0);
      checkOutput("E_c2_addr", imem_addr, 32'h4);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("E_c4_tvalid", inst_tvalid, 1'b0);
      nextCycle(); applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("E_c5_tdata", inst_tdata, 32'h0011_0113);
`ifdef IF_PC_TAG_EN
      checkOutput("E_c5_tpc", inst_tpc, 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
